// File: rtl/step_pkg.sv
// Shared types and default timing constants for the step controller.
package step_pkg;

  localparam int unsigned DEBOUNCE_DEFAULT = 1_000_000;
  localparam int unsigned BASE_DIV_DEFAULT = 50_000_000;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } db_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/step_controller.sv
// Single-step / auto-run step enable generator with
// a debounced push-button and a selectable-rate divider.
module step_controller
  import step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned BASE_DIV        = BASE_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_n,
  input  logic        run,
  input  logic [1:0]  rate_sel,
  output logic        step,
  output logic        key_level,
  output logic [15:0] step_cnt
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DIV_W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic key_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (key_n),
    .q     (key_s)
  );

  db_state_e       state_q, state_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            key_level_q, key_level_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic            run_q, run_d;
  logic [1:0]      rate_q, rate_d;
  logic            step_q, step_d;
  logic [15:0]     step_cnt_q, step_cnt_d;

  logic             key_lo;
  logic             db_last;
  logic             key_step;
  logic             auto_step;
  logic [31:0]      period;
  logic [DIV_W-1:0] div_last;

  always_comb begin
    period = BASE_DIV >> {rate_sel, 1'b0};
    if (period == 32'd0) period = 32'd1;
    div_last = DIV_W'(period - 32'd1);
  end

  always_comb begin
    key_lo      = ~key_s;
    db_last     = (db_cnt_q == DB_LAST);
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    key_level_d = key_level_q;
    key_step    = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (key_lo) begin
          state_d  = PRESS_CHK;
          db_cnt_d = '0;
        end
      end
      PRESS_CHK: begin
        if (!key_lo) begin
          state_d = RELEASED;
        end else if (db_last) begin
          state_d     = PRESSED;
          key_level_d = 1'b1;
          key_step    = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      PRESSED: begin
        if (!key_lo) begin
          state_d  = RELEASE_CHK;
          db_cnt_d = '0;
        end
      end
      RELEASE_CHK: begin
        if (key_lo) begin
          state_d = PRESSED;
        end else if (db_last) begin
          state_d     = RELEASED;
          key_level_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  // Leaving run, entering run or a new rate all restart the period at 0.
  always_comb begin
    run_d     = run;
    rate_d    = rate_sel;
    div_d     = div_q;
    auto_step = 1'b0;
    if (!run || !run_q || (rate_sel != rate_q)) begin
      div_d = '0;
    end else if (div_q == div_last) begin
      div_d     = '0;
      auto_step = 1'b1;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_comb begin
    step_d     = auto_step | (key_step & ~run);
    step_cnt_d = step_d ? step_cnt_q + 16'd1 : step_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RELEASED;
      db_cnt_q    <= '0;
      key_level_q <= 1'b0;
      div_q       <= '0;
      run_q       <= 1'b0;
      rate_q      <= 2'b00;
      step_q      <= 1'b0;
      step_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      key_level_q <= key_level_d;
      div_q       <= div_d;
      run_q       <= run_d;
      rate_q      <= rate_d;
      step_q      <= step_d;
      step_cnt_q  <= step_cnt_d;
    end
  end

  assign step      = step_q;
  assign key_level = key_level_q;
  assign step_cnt  = step_cnt_q;

endmodule
